usb_rx_pkt_ctrl: RTL
====================

# usb_rx_pkt_ctrl

Parametrised receive-control FSM for the USB-style serial receiver in Julia_Worker. It sits beside the bit decoder, shift register and receive FIFO. It validates the SYNC byte, gates one FIFO write per received byte, and enforces a maximum payload length and FIFO back-pressure. It reports a packet-done pulse, a running byte count and a coded error cause.

## Interface
- SYNC_BYTE, 8'h80: required first byte after SYNC reception
- MAX_BYTES, 64: maximum payload bytes per packet (1..255)
- CNT_W, $clog2(MAX_BYTES+1): byte_count width
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- d_edge  in  1  line transition detected (1-cycle pulse)
- eop  in  1  end-of-packet line condition
- shift_enable  in  1  bit-sample strobe
- byte_received  in  1  8 bits shifted in (1-cycle pulse)
- rcv_data  in  8  last received byte
- fifo_full  in  1  receive FIFO cannot accept a write
- rcving  out  1  packet reception in progress
- w_enable  out  1  FIFO write strobe
- r_error  out  1  error present, sticky until next packet start
- err_code  out  2  0 none, 1 bad SYNC, 2 misaligned EOP, 3 overflow (MAX_BYTES exceeded or fifo_full)
- byte_count  out  CNT_W  payload bytes written in current/last packet
- pkt_done  out  1  1-cycle pulse on clean packet end

## Operation
- States: IDLE, RCV_SYNC, COMPARE, RCV_BITS, WRITE, WAIT_BIT, EOP_END, ERR_EOP, ERR_EDGE, ERR_IDLE.
- IDLE: d_edge goes to RCV_SYNC.
- RCV_SYNC: byte_received goes to COMPARE.
- COMPARE (1 cycle): rcv_data==SYNC_BYTE goes to RCV_BITS and clears byte_count. Otherwise go to ERR_EOP with err_code=1.
- RCV_BITS: on byte_received:
  - byte_count==MAX_BYTES: go to ERR_EOP, err_code=3.
  - else fifo_full: go to ERR_EOP, err_code=3.
  - else go to WRITE.
- RCV_BITS, without byte_received: shift_enable&&eop goes to ERR_EDGE with err_code=2.
- byte_received has priority over eop in the same cycle.
- WRITE (1 cycle): w_enable=1, byte_count+1, then WAIT_BIT.
- WAIT_BIT:
  - shift_enable&&eop goes to EOP_END.
  - shift_enable&&!eop goes to RCV_BITS.
- EOP_END: d_edge goes to IDLE and asserts pkt_done that cycle.
- ERR_EOP: shift_enable&&eop goes to ERR_EDGE.
- ERR_EDGE: d_edge goes to ERR_IDLE.
- ERR_IDLE: d_edge goes to RCV_SYNC.
- Outputs:
  - rcving=1 in every state except IDLE and ERR_IDLE.
  - r_error=1 in ERR_EOP, ERR_EDGE and ERR_IDLE.
  - w_enable only in WRITE.
- err_code is registered:
  - set on entry to ERR_EOP or ERR_EDGE;
  - cleared on the transition into RCV_SYNC;
  - holds otherwise.
- byte_count is registered; it holds after packet end until the next accepted SYNC. It never exceeds MAX_BYTES.

## Timing
- Reset values: state=IDLE, rcving=0, w_enable=0, r_error=0, err_code=0, byte_count=0, pkt_done=0.
- Reset mid-packet aborts immediately. No write is issued and error state is lost.
- rcving, w_enable and r_error are combinational decodes of state (Moore).
- pkt_done is the Mealy decode (state==EOP_END)&&d_edge.
- Latency from byte_received in RCV_BITS:
  - w_enable asserts the next cycle, exactly one cycle wide;
  - byte_count increments on the same edge that leaves WRITE.
- Minimum SYNC-to-first-write: byte_received in RCV_SYNC, then COMPARE, then RCV_BITS. Writes are spaced at least one cycle apart.
- fifo_full is sampled only in the byte_received cycle. A byte refused for a full FIFO is never written.

## Structure
- usb_rx_pkg holds:
  - typedef enum logic[3:0] rx_state_t (ten states above);
  - typedef enum logic[1:0] rx_err_t (ERR_NONE, ERR_SYNC, ERR_ALIGN, ERR_OVF).
- Single module with no sub-module. The counter, error register and FSM are inline, with the state register on its own async-reset always_ff.

## Test plan
- Clean packet: SYNC 8'h80, bytes 8'hA5, 8'h3C, then EOP and d_edge. Required: two 1-cycle w_enable pulses, byte_count=2, one pkt_done, r_error=0 throughout.
- Bad SYNC: first byte 8'h81. Required: r_error=1, err_code=1, no w_enable. Required after EOP and two d_edge: rcving=1 in RCV_SYNC and err_code=0.
- Misaligned EOP: SYNC, then shift_enable&&eop in RCV_BITS with no byte_received. Required: ERR_EDGE, err_code=2, no write; after d_edge: ERR_IDLE, rcving=0, r_error=1.
- Overflow: MAX_BYTES=4, send SYNC plus 5 bytes. Required: exactly 4 writes, byte_count=4, err_code=3 on the 5th byte_received.
- FIFO back-pressure: fifo_full=1 coincident with the 2nd byte_received. Required: 1 write, err_code=3, ERR_EOP.
- Reset mid-packet: deassert n_rst while in WAIT_BIT after 3 bytes. Required: all outputs at reset values in the same cycle and state IDLE on release.

Source files
------------

// File: rtl/usb_rx_pkt_ctrl_pkg.sv
// Shared types for the USB receive-control block: FSM state encoding and error causes.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RCV_SYNC,
    COMPARE,
    RCV_BITS,
    WRITE,
    WAIT_BIT,
    EOP_END,
    ERR_EOP,
    ERR_EDGE,
    ERR_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SYNC,
    ERR_ALIGN,
    ERR_OVF
  } rx_err_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'h80;
  localparam int         DEF_MAX_BYTES = 64;

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Line-side strobes in, FIFO write/status out; master drives the decoder side, slave is the controller.
interface usb_rx_pkt_ctrl_if #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
);
  logic             d_edge;
  logic             eop;
  logic             shift_enable;
  logic             byte_received;
  logic [7:0]       rcv_data;
  logic             fifo_full;
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] byte_count;
  logic             pkt_done;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    input  rcving, w_enable, r_error, err_code, byte_count, pkt_done
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    output rcving, w_enable, r_error, err_code, byte_count, pkt_done
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive-control FSM: checks SYNC, issues one FIFO write per byte, caps payload length and
// flags bad SYNC / misaligned EOP / overflow. Moore status outputs, Mealy pkt_done.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         MAX_BYTES = DEF_MAX_BYTES,
  parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_pkt_ctrl_if.slave   bus
);

  rx_state_t        state_q, state_d;
  rx_err_t          err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= ERR_NONE;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.d_edge) begin
        state_d = RCV_SYNC;
        err_d   = ERR_NONE;
      end
      RCV_SYNC: if (bus.byte_received) state_d = COMPARE;
      COMPARE: begin
        if (bus.rcv_data == SYNC_BYTE) begin
          state_d = RCV_BITS;
          cnt_d   = '0;
        end else begin
          state_d = ERR_EOP;
          err_d   = ERR_SYNC;
        end
      end
      // A completed byte outranks a coincident EOP sample.
      RCV_BITS: begin
        if (bus.byte_received) begin
          if (cnt_q == CNT_W'(MAX_BYTES) || bus.fifo_full) begin
            state_d = ERR_EOP;
            err_d   = ERR_OVF;
          end else begin
            state_d = WRITE;
          end
        end else if (bus.shift_enable && bus.eop) begin
          state_d = ERR_EDGE;
          err_d   = ERR_ALIGN;
        end
      end
      WRITE: begin
        state_d = WAIT_BIT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT_BIT: if (bus.shift_enable) state_d = bus.eop ? EOP_END : RCV_BITS;
      EOP_END:  if (bus.d_edge) state_d = IDLE;
      ERR_EOP:  if (bus.shift_enable && bus.eop) state_d = ERR_EDGE;
      ERR_EDGE: if (bus.d_edge) state_d = ERR_IDLE;
      ERR_IDLE: if (bus.d_edge) begin
        state_d = RCV_SYNC;
        err_d   = ERR_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rcving     = (state_q != IDLE) && (state_q != ERR_IDLE);
  assign bus.r_error    = (state_q == ERR_EOP) || (state_q == ERR_EDGE) || (state_q == ERR_IDLE);
  assign bus.w_enable   = (state_q == WRITE);
  assign bus.pkt_done   = (state_q == EOP_END) && bus.d_edge;
  assign bus.err_code   = err_q;
  assign bus.byte_count = cnt_q;

endmodule
